// File: rtl/writeback_stage_if.sv
// MEM-to-WB bundle: MEM-stage result inputs plus the register-file write
// port and forwarding bus that the writeback stage drives.
interface writeback_stage_if #(
    parameter int COUNT_WIDTH = 32
);
    logic                   mem_valid;
    logic                   mem_regWrite;
    logic                   mem_memToReg;
    logic [2:0]             mem_loadType;
    logic [1:0]             mem_addrLow;
    logic [4:0]             mem_writeReg;
    logic [31:0]            mem_aluResult;
    logic [31:0]            mem_readData;
    logic                   stall;
    logic                   flush;

    logic                   regWrite;
    logic [4:0]             writeReg;
    logic [31:0]            writeData;
    logic                   fwd_valid;
    logic [4:0]             fwd_reg;
    logic [31:0]            fwd_data;
    logic                   misaligned;
    logic [COUNT_WIDTH-1:0] retired;

    modport master (
        output mem_valid, mem_regWrite, mem_memToReg, mem_loadType, mem_addrLow,
               mem_writeReg, mem_aluResult, mem_readData, stall, flush,
        input  regWrite, writeReg, writeData, fwd_valid, fwd_reg, fwd_data,
               misaligned, retired
    );

    modport slave (
        input  mem_valid, mem_regWrite, mem_memToReg, mem_loadType, mem_addrLow,
               mem_writeReg, mem_aluResult, mem_readData, stall, flush,
        output regWrite, writeReg, writeData, fwd_valid, fwd_reg, fwd_data,
               misaligned, retired
    );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with load-data extraction; drives the register
// file write port, the EX forwarding bus and a retired-instruction counter.
module writeback_stage #(
    parameter int COUNT_WIDTH = 32
) (
    input logic               clock_in,
    input logic               reset,
    writeback_stage_if.slave  wb
);
    logic [7:0]             loadByte;
    logic [15:0]            loadHalf;
    logic [31:0]            loadValue;
    logic                   loadMisaligned;
    logic                   misalignedNext;
    logic [31:0]            dataNext;
    logic                   writeEnNext;
    logic                   bubble;

    logic                   validQ;
    logic                   regWriteQ;
    logic [4:0]             writeRegQ;
    logic [31:0]            writeDataQ;
    logic                   misalignedQ;
    logic [COUNT_WIDTH-1:0] retiredQ;

    always_comb begin
        loadByte       = '0;
        loadHalf       = '0;
        loadValue      = wb.mem_readData;
        loadMisaligned = (wb.mem_addrLow != 2'd0);

        case (wb.mem_addrLow)
            2'd0:    loadByte = wb.mem_readData[7:0];
            2'd1:    loadByte = wb.mem_readData[15:8];
            2'd2:    loadByte = wb.mem_readData[23:16];
            default: loadByte = wb.mem_readData[31:24];
        endcase
        loadHalf = wb.mem_addrLow[1] ? wb.mem_readData[31:16] : wb.mem_readData[15:0];

        // Codes 5..7 fall through to the LW defaults above.
        case (wb.mem_loadType)
            3'd1: begin
                loadValue      = {{24{loadByte[7]}}, loadByte};
                loadMisaligned = 1'b0;
            end
            3'd2: begin
                loadValue      = {24'd0, loadByte};
                loadMisaligned = 1'b0;
            end
            3'd3: begin
                loadValue      = {{16{loadHalf[15]}}, loadHalf};
                loadMisaligned = wb.mem_addrLow[0];
            end
            3'd4: begin
                loadValue      = {16'd0, loadHalf};
                loadMisaligned = wb.mem_addrLow[0];
            end
            default: ;
        endcase
    end

    assign misalignedNext = wb.mem_memToReg & loadMisaligned;
    assign dataNext       = wb.mem_memToReg ? loadValue : wb.mem_aluResult;
    assign writeEnNext    = wb.mem_regWrite & ~misalignedNext & (wb.mem_writeReg != 5'd0);
    assign bubble         = wb.stall | wb.flush | ~wb.mem_valid;

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            validQ      <= 1'b0;
            regWriteQ   <= 1'b0;
            writeRegQ   <= '0;
            writeDataQ  <= '0;
            misalignedQ <= 1'b0;
            retiredQ    <= '0;
        end else begin
            // Count what is leaving WB on this edge, before it is replaced.
            if (validQ) begin
                retiredQ <= retiredQ + COUNT_WIDTH'(1);
            end
            if (bubble) begin
                validQ      <= 1'b0;
                regWriteQ   <= 1'b0;
                writeRegQ   <= '0;
                writeDataQ  <= '0;
                misalignedQ <= 1'b0;
            end else begin
                validQ      <= 1'b1;
                regWriteQ   <= writeEnNext;
                writeRegQ   <= wb.mem_writeReg;
                writeDataQ  <= dataNext;
                misalignedQ <= misalignedNext;
            end
        end
    end

    assign wb.regWrite   = regWriteQ;
    assign wb.writeReg   = writeRegQ;
    assign wb.writeData  = writeDataQ;
    assign wb.fwd_valid  = regWriteQ;
    assign wb.fwd_reg    = writeRegQ;
    assign wb.fwd_data   = writeDataQ;
    assign wb.misaligned = misalignedQ;
    assign wb.retired    = retiredQ;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized bench for writeback_stage against a behavioural
// model of load extraction, write enables and retire counting.
module tb_writeback_stage;
    logic clock_in = 1'b0;
    logic reset    = 1'b0;
    int   tests    = 0;
    int   failed   = 0;

    writeback_stage_if #(.COUNT_WIDTH(32)) wbIf ();
    writeback_stage_if #(.COUNT_WIDTH(4))  wrapIf ();

    writeback_stage #(.COUNT_WIDTH(32)) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .wb       (wbIf.slave)
    );

    writeback_stage #(.COUNT_WIDTH(4)) dutWrap (
        .clock_in (clock_in),
        .reset    (reset),
        .wb       (wrapIf.slave)
    );

    always #5 clock_in = ~clock_in;

    logic        mValid, mRw, mMis;
    logic [4:0]  mWr;
    logic [31:0] mWd;
    logic [31:0] mRet;

    function automatic logic [31:0] extract(int lt, int a, logic [31:0] rd);
        int unsigned b, h;
        b = (rd >> (8 * a)) & 32'hFF;
        h = (rd >> (16 * (a / 2))) & 32'hFFFF;
        case (lt)
            1: return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            2: return 32'(b);
            3: return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            4: return 32'(h);
            default: return rd;
        endcase
    endfunction

    function automatic logic isMisaligned(int lt, int a);
        if (lt == 1 || lt == 2) return 1'b0;
        if (lt == 3 || lt == 4) return (a % 2) == 1;
        return a != 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(string tag);
        chk({tag, ".regWrite"},   32'(wbIf.regWrite),   32'(mRw));
        chk({tag, ".writeReg"},   32'(wbIf.writeReg),   32'(mWr));
        chk({tag, ".writeData"},  wbIf.writeData,       mWd);
        chk({tag, ".fwd_valid"},  32'(wbIf.fwd_valid),  32'(mRw));
        chk({tag, ".fwd_reg"},    32'(wbIf.fwd_reg),    32'(mWr));
        chk({tag, ".fwd_data"},   wbIf.fwd_data,        mWd);
        chk({tag, ".misaligned"}, 32'(wbIf.misaligned), 32'(mMis));
        chk({tag, ".retired"},    wbIf.retired,         mRet);
    endtask

    task automatic modelReset();
        mValid = 0; mRw = 0; mMis = 0; mWr = 0; mWd = 0; mRet = 0;
    endtask

    task automatic setIn(logic v, logic rw, logic m2r, int lt, int a, int wr,
                         logic [31:0] alu, logic [31:0] rd, logic st, logic fl);
        wbIf.mem_valid     = v;
        wbIf.mem_regWrite  = rw;
        wbIf.mem_memToReg  = m2r;
        wbIf.mem_loadType  = 3'(lt);
        wbIf.mem_addrLow   = 2'(a);
        wbIf.mem_writeReg  = 5'(wr);
        wbIf.mem_aluResult = alu;
        wbIf.mem_readData  = rd;
        wbIf.stall         = st;
        wbIf.flush         = fl;
    endtask

    task automatic tick(string tag);
        logic        nV, nRw, nMis;
        logic [4:0]  nWr;
        logic [31:0] nWd;
        int lt, a;
        lt = int'(wbIf.mem_loadType);
        a  = int'(wbIf.mem_addrLow);
        if (wbIf.stall || wbIf.flush || !wbIf.mem_valid) begin
            nV = 0; nRw = 0; nMis = 0; nWr = 0; nWd = 0;
        end else begin
            nV   = 1;
            nMis = wbIf.mem_memToReg && isMisaligned(lt, a);
            nWd  = wbIf.mem_memToReg ? extract(lt, a, wbIf.mem_readData) : wbIf.mem_aluResult;
            nWr  = wbIf.mem_writeReg;
            nRw  = wbIf.mem_regWrite && !nMis && (wbIf.mem_writeReg != 0);
        end
        @(posedge clock_in);
        #1;
        if (mValid) mRet = mRet + 1;
        mValid = nV; mRw = nRw; mMis = nMis; mWr = nWr; mWd = nWd;
        checkAll(tag);
    endtask

    initial begin
        wrapIf.mem_valid = 0; wrapIf.mem_regWrite = 0; wrapIf.mem_memToReg = 0;
        wrapIf.mem_loadType = 0; wrapIf.mem_addrLow = 0; wrapIf.mem_writeReg = 0;
        wrapIf.mem_aluResult = 0; wrapIf.mem_readData = 0; wrapIf.stall = 0; wrapIf.flush = 0;
        modelReset();

        // Reset held with random, valid-looking inputs
        setIn(1, 1, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3),
              $urandom_range(1, 31), $urandom, $urandom, 0, 0);
        #3;
        checkAll("rst0");
        repeat (3) @(posedge clock_in);
        #1;
        checkAll("rst1");
        chk("rstWrap", 32'(wrapIf.retired), 32'd0);
        reset = 1'b1;
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("bubble");
        tick("bubble2");

        // ALU write
        setIn(1, 1, 0, 0, 0, 8, 32'h12345678, $urandom, 0, 0);
        tick("alu");
        chk("alu.data", wbIf.writeData, 32'h12345678);
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("alu.after");
        chk("alu.ret", wbIf.retired, 32'd1);

        // Loads from a fixed word
        setIn(1, 1, 1, 1, 2, 9, $urandom, 32'h80FF7F01, 0, 0);
        tick("lb2");  chk("lb2.data", wbIf.writeData, 32'hFFFFFFFF);
        setIn(1, 1, 1, 2, 3, 10, $urandom, 32'h80FF7F01, 0, 0);
        tick("lbu3"); chk("lbu3.data", wbIf.writeData, 32'h00000080);
        setIn(1, 1, 1, 3, 2, 11, $urandom, 32'h80FF7F01, 0, 0);
        tick("lh2");  chk("lh2.data", wbIf.writeData, 32'hFFFF80FF);
        setIn(1, 1, 1, 4, 0, 12, $urandom, 32'h80FF7F01, 0, 0);
        tick("lhu0"); chk("lhu0.data", wbIf.writeData, 32'h00007F01);
        setIn(1, 1, 1, 0, 0, 13, $urandom, 32'h80FF7F01, 0, 0);
        tick("lw0");  chk("lw0.data", wbIf.writeData, 32'h80FF7F01);

        // Misaligned loads
        setIn(1, 1, 1, 3, 1, 14, $urandom, 32'h80FF7F01, 0, 0);
        tick("lh1");  chk("lh1.mis", 32'(wbIf.misaligned), 32'd1);
        chk("lh1.rw", 32'(wbIf.regWrite), 32'd0);
        setIn(1, 1, 1, 0, 2, 15, $urandom, 32'h80FF7F01, 0, 0);
        tick("lw2");  chk("lw2.mis", 32'(wbIf.misaligned), 32'd1);

        // $zero destination
        setIn(1, 1, 0, 0, 0, 0, 32'hDEADBEEF, $urandom, 0, 0);
        tick("zero"); chk("zero.data", wbIf.writeData, 32'hDEADBEEF);
        chk("zero.rw", 32'(wbIf.regWrite), 32'd0);

        // Stall / flush / both, then back-to-back writes to one register
        setIn(1, 1, 0, 0, 0, 5, 32'hA5A5A5A5, 0, 1, 0);
        tick("stall");
        setIn(1, 1, 0, 0, 0, 5, 32'h5A5A5A5A, 0, 0, 1);
        tick("flush");
        setIn(1, 1, 0, 0, 0, 5, 32'h0F0F0F0F, 0, 1, 1);
        tick("both");
        setIn(1, 1, 0, 0, 0, 7, 32'h00000001, 0, 0, 0);
        tick("b2b0");
        setIn(1, 1, 0, 0, 0, 7, 32'h00000002, 0, 0, 0);
        tick("b2b1"); chk("b2b1.data", wbIf.writeData, 32'h00000002);

        // Mid-operation reset drops the in-flight instruction
        setIn(1, 1, 0, 0, 0, 20, 32'hCAFEF00D, 0, 0, 0);
        tick("preRst");
        reset = 1'b0;
        #2;
        modelReset();
        checkAll("midRst");
        @(posedge clock_in);
        #1;
        reset = 1'b1;
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("postRst");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            setIn($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31),
                  $urandom, $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            tick("rand");
        end

        // Counter wrap on the 4-bit instance
        for (int i = 0; i < 17; i++) begin
            wrapIf.mem_valid     = 1;
            wrapIf.mem_regWrite  = 1'($urandom_range(0, 1));
            wrapIf.mem_writeReg  = 5'($urandom);
            wrapIf.mem_aluResult = $urandom;
            @(posedge clock_in);
            #1;
        end
        chk("wrap16", 32'(wrapIf.retired), 32'd0);
        wrapIf.mem_valid = 0;
        @(posedge clock_in);
        #1;
        chk("wrap17", 32'(wrapIf.retired), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

MEM/WB pipeline register and write-back driver for the pipelined MIPS CPU. It captures the MEM-stage result and performs load-data extraction (LW/LB/LBU/LH/LHU). One cycle later it drives the register file write port (`regWrite`, `writeReg`, `writeData`) and the matching forwarding bus to EX. It is the producer end of the register file's write interface. It also counts retired instructions for bench and debug use.

## Interface
Parameters:
- `COUNT_WIDTH`, 32, width of the retired-instruction counter.

Ports:
- `clock_in` in 1: the single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `mem_valid` in 1: the MEM stage holds a real instruction.
- `mem_regWrite` in 1: the instruction writes a GPR.
- `mem_memToReg` in 1: 1 selects load data, 0 selects the ALU result.
- `mem_loadType` in 3: 0=LW, 1=LB, 2=LBU, 3=LH, 4=LHU; values 5–7 are treated as LW.
- `mem_addrLow` in 2: byte offset of the load address, `aluResult[1:0]`.
- `mem_writeReg` in 5: destination register.
- `mem_aluResult` in 32: ALU result / effective address.
- `mem_readData` in 32: data-memory read word, valid in the same cycle as the other `mem_*` inputs.
- `stall` in 1: the MEM stage is held; WB receives a bubble.
- `flush` in 1: kill the MEM instruction; WB receives a bubble.
- `regWrite` out 1: register-file write enable.
- `writeReg` out 5: register-file write address.
- `writeData` out 32: register-file write data.
- `fwd_valid` out 1: forwarding bus valid. Always equal to `regWrite`.
- `fwd_reg` out 5: equal to `writeReg`.
- `fwd_data` out 32: equal to `writeData`.
- `misaligned` out 1: the instruction now in WB was a misaligned load.
- `retired` out COUNT_WIDTH: count of valid instructions that left WB.

## Operation
- **Capture.** A bubble is loaded when `stall | flush | !mem_valid`; otherwise the MEM/WB register loads the next instruction. There is no hold mode; the register is refreshed every cycle. A bubble means: `valid=0`, write enable 0, and `writeReg`/`writeData` cleared to 0.
- **Load extraction** is combinational on the `mem_*` inputs, before capture. The byte order is little-endian.
  - LB/LBU select `mem_readData[8*addrLow+7 : 8*addrLow]`. LB sign-extends from bit 7; LBU zero-extends.
  - LH/LHU select the half given by `addrLow[1]` (0 = bits 15:0, 1 = bits 31:16). LH sign-extends from bit 15; LHU zero-extends.
  - LW passes `mem_readData` unchanged. `addrLow` is still checked for alignment.
- **Result select.** The captured data is the extracted load value when `mem_memToReg=1`, otherwise `mem_aluResult`.
- **Misalignment check.** A load (`memToReg=1`) is misaligned if it is LW/default with `addrLow != 0`, or LH/LHU with `addrLow[0]=1`.
  - The `misaligned` flag is captured for that instruction.
  - Its write enable is forced to 0.
  - `writeData` still carries the selected value.
- **$zero suppression.** The write enable is forced to 0 when `mem_writeReg == 0`. `writeReg` is still driven as 0.
- **Output enable.** `regWrite = valid & captured write enable`.
- **Retired counter.** `retired` increments by 1 on each edge at which the current WB content is valid. This includes non-writing, misaligned, and $zero instructions. It wraps modulo 2^COUNT_WIDTH.

## Timing
- **Latency.** Inputs sampled at edge N appear on all outputs after edge N and stay stable until edge N+1. All outputs are registered; there is no combinational path from input to output.
- **Register-file interface.** The register file samples `regWrite`/`writeReg`/`writeData` at edge N+1. Each instruction is presented for exactly one cycle, giving exactly one write.
- **Reset.** While `reset=0`, all outputs are forced to 0 asynchronously (`regWrite`, `writeReg`, `writeData`, `fwd_*`, `misaligned`, `retired`) and valid is 0.
  - The first capture is at the first rising edge after `reset` deasserts.
  - Reset asserted mid-operation drops the in-flight instruction with no write.
- **Priority.** `flush` and `stall` are equivalent and may be asserted together; either one gives a bubble.
- **Back-to-back writes** to the same register produce writes in consecutive cycles, in program order.

## Test plan
1. **Reset.** Hold `reset=0` and drive all inputs to random values, including `mem_valid=1`. Expect every output to be 0. Release reset, apply one bubble, and expect `retired` to stay 0.
2. **ALU write.** `mem_valid=1`, `regWrite=1`, `memToReg=0`, `writeReg=8`, `aluResult=0x12345678`. Expect `regWrite=1`, `writeReg=8`, `writeData=0x12345678` for one cycle. Expect `fwd_*` identical and `retired=1`.
3. **Loads** with `readData=0x80FF7F01`:
   - LB at `addrLow=2` → `0xFFFFFFFF`.
   - LBU at `addrLow=3` → `0x00000080`.
   - LH at `addrLow=2` → `0xFFFF80FF`.
   - LHU at `addrLow=0` → `0x00007F01`.
   - LW at `addrLow=0` → `0x80FF7F01`.
4. **Misaligned load.** LH at `addrLow=1` → `misaligned=1`, `regWrite=0`. LW at `addrLow=2` → same result. `retired` still increments for both.
5. **$zero write.** `writeReg=0`, `aluResult=0xDEADBEEF` → `regWrite=0`, `writeData=0xDEADBEEF`, `retired` increments.
6. **Stall, flush, counter wrap.**
   - A valid instruction with `stall=1` → a bubble in the next cycle (`regWrite=0`, `retired` unchanged).
   - Same with `flush=1`, and with both asserted.
   - With `COUNT_WIDTH=4`, retire 17 instructions → `retired=1`.
